// File: rtl/mips_dm_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
package mips_dm_pkg;

  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 7;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

endpackage

// File: rtl/mips_dm_ram.sv
// Single-port word RAM: per-byte synchronous write, combinational read,
// cleared to zero by the asynchronous active-low reset.
module mips_dm_ram
  import mips_dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     idx,
  input  logic [BE_W-1:0]   we_be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < BE_W; b++)
        if (we_be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mips_dm_responder.sv
// Fixed-latency data-memory responder for a MIPS core (one request in flight).
// Optional store logging is enabled with `define MIPS_DM_WRITE_LOG_EN.
module mips_dm_responder
  import mips_dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DATA_W:0]  LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dm_state_e         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              we_p0;
  logic [DATA_W-1:0] addr_p0;
  logic [BE_W-1:0]   be_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              accept, access, err_p0;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_rdata;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign access    = (state == WAIT) && (cnt == '0);
  assign err_p0    = (addr_p0[1:0] != 2'b00) || ({1'b0, addr_p0} >= LIMIT);
  assign ram_be    = (access && we_p0 && !err_p0) ? be_p0 : '0;

  // Stage p0: request captured on accept; data path carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      be_p0    <= req_be;
      wdata_p0 <= req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: access edge registers the response held through RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= CNT_INIT;
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (access) begin
        rsp_err   <= err_p0;
        rsp_rdata <= (err_p0 || we_p0) ? '0 : ram_rdata;
      end
    end
  end

  mips_dm_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .reset (reset),
    .idx   (addr_p0[AW+1:2]),
    .we_be (ram_be),
    .wdata (wdata_p0),
    .rdata (ram_rdata)
  );

`ifdef MIPS_DM_WRITE_LOG_EN
  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] log_word;

  always_ff @(posedge clk) begin
    if (accept) pc_p0 <= req_pc;
  end

  always_comb begin
    log_word = ram_rdata;
    for (int b = 0; b < BE_W; b++)
      if (be_p0[b]) log_word[8*b +: 8] = wdata_p0[8*b +: 8];
  end

  // Printed on the access edge only; reset-discarded and error stores never reach here
  always_ff @(posedge clk) begin
    if (reset && access && we_p0 && !err_p0 && be_p0 != '0)
      $display("@%08h: *%08h <= %08h", pc_p0, {addr_p0[DATA_W-1:2], 2'b00}, log_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_mips_dm_responder.sv
// Self-checking bench: LATENCY=1 directed table plus LATENCY=7 randomized scoreboard run.
module tb_mips_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic [3:0]  req_be = '0;
  logic        v1, v7, rdy1, rdy7, val1, val7, er1, er7;
  logic [31:0] rd1, rd7;
  logic        r_ready, r_valid, r_err;
  logic [31:0] r_rdata;
  int          cyc = 0;
  int          nchk = 0, nerr = 0;

  localparam int D7 = 64;
  logic [31:0] mdl [D7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign v1      = req_valid & ~sel;
  assign v7      = req_valid & sel;
  assign r_ready = sel ? rdy7 : rdy1;
  assign r_valid = sel ? val7 : val1;
  assign r_err   = sel ? er7  : er1;
  assign r_rdata = sel ? rd7  : rd1;

  mips_dm_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(val1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1));

  mips_dm_responder #(.DEPTH_WORDS(D7), .LATENCY(7)) u_dut7 (
    .clk(clk), .reset(rst_n), .req_valid(v7), .req_ready(rdy7), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(val7), .rsp_ready(rsp_ready), .rsp_rdata(rd7), .rsp_err(er7));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] pc,
                       output int acc, output bit ok);
    ok = 1'b0;
    acc = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_be = be; req_wdata = wd; req_pc = pc;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (r_ready) begin ok = 1'b1; acc = cyc; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int when, output bit ok);
    ok = 1'b0;
    when = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r_valid) begin ok = 1'b1; when = cyc; break; end
    end
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic [31:0] pc,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int acc, when;
    bit ok;
    issue(we, addr, be, wd, pc, acc, ok);
    if (!ok) begin timeout({name, "_accept"}); return; end
    wait_rsp(when, ok);
    if (!ok) begin timeout({name, "_rsp"}); return; end
    chk({name, "_rdata"}, r_rdata, exp_rd);
    chk({name, "_err"}, {31'b0, r_err}, {31'b0, exp_err});
    chk({name, "_lat"}, when - acc, exp_lat);
    take();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D7; i++) mdl[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, when;
    bit ok;
    logic [31:0] held;

    tbl[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h3000, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,       4'hF, 32'h0,        32'h3000, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,       4'h2, 32'h0000AB00, 32'h3004, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,       4'hF, 32'h0,        32'h3008, 32'hDEADABEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h13,       4'hF, 32'h0,        32'h300C, 32'h0,        1'b1};
    tbl[5]  = '{1'b1, 32'h1000,     4'hF, 32'h12345678, 32'h3010, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 32'h10,       4'hF, 32'h0,        32'h3014, 32'hDEADABEF, 1'b0};
    tbl[7]  = '{1'b1, 32'h14,       4'h0, 32'hFFFFFFFF, 32'h3018, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h14,       4'hF, 32'h0,        32'h301C, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 32'hFFC,      4'h8, 32'hA5FFFFFF, 32'h3020, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'hFFC,      4'hF, 32'h0,        32'h3024, 32'hA5000000, 1'b0};
    tbl[11] = '{1'b0, 32'hFFFFFFF0, 4'hF, 32'h0,        32'h3028, 32'h0,        1'b1};
    tbl[12] = '{1'b1, 32'h12,       4'hF, 32'h11111111, 32'h302C, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 32'h10,       4'h0, 32'h0,        32'h3030, 32'hDEADABEF, 1'b0};

    // reset state
    #12;
    chk("reset_rsp_valid", {31'b0, r_valid}, 32'd0);
    chk("reset_req_ready", {31'b0, r_ready}, 32'd1);
    chk("reset_rdata", r_rdata, 32'h0);
    chk("reset_err", {31'b0, r_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table, LATENCY=1
    for (int i = 0; i < 14; i++)
      do_req($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd,
             tbl[i].pc, tbl[i].exp_rd, tbl[i].exp_err, 2);

    // stalled response with an ignored request pulse
    issue(1'b0, 32'h10, 4'hF, 32'h0, 32'h3100, acc, ok);
    if (!ok) timeout("stall_accept");
    wait_rsp(when, ok);
    if (!ok) timeout("stall_rsp");
    else begin
      held = r_rdata;
      chk("stall_first_rdata", held, 32'hDEADABEF);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("stall%0d_valid", i), {31'b0, r_valid}, 32'd1);
        chk($sformatf("stall%0d_rdata", i), r_rdata, held);
        chk($sformatf("stall%0d_ready", i), {31'b0, r_ready}, 32'd0);
        if (i == 3) begin
          req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0;
          req_valid = 1'b1;
        end
        if (i == 4) req_valid = 1'b0;
        @(negedge clk);
      end
      take();
      @(negedge clk);
      chk("stall_after_ready", {31'b0, r_ready}, 32'd1);
    end
    do_req("stall_ignored_store", 1'b0, 32'h10, 4'hF, 32'h0, 32'h3104, 32'hDEADABEF, 1'b0, 2);

    // reset asserted while a response is held
    do_req("rr_store", 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h3200, 32'h0, 1'b0, 2);
    issue(1'b0, 32'h20, 4'hF, 32'h0, 32'h3204, acc, ok);
    wait_rsp(when, ok);
    if (!ok) timeout("rr_rsp");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_valid_low", {31'b0, r_valid}, 32'd0);
    chk("rr_ready_high", {31'b0, r_ready}, 32'd1);
    chk("rr_rdata_zero", r_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("rr_load_after", 1'b0, 32'h20, 4'hF, 32'h0, 32'h3208, 32'h0, 1'b0, 2);
    do_req("rr_load_10", 1'b0, 32'h10, 4'hF, 32'h0, 32'h320C, 32'h0, 1'b0, 2);

    // LATENCY=7: reset during WAIT discards the store
    sel = 1'b1;
    issue(1'b1, 32'h8, 4'hF, 32'h11111111, 32'h3300, acc, ok);
    if (!ok) timeout("rw_accept");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rw_valid_low", {31'b0, r_valid}, 32'd0);
    chk("rw_ready_high", {31'b0, r_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_req("rw_load", 1'b0, 32'h8, 4'hF, 32'h0, 32'h3304, 32'h0, 1'b0, 8);

    // LATENCY=7 randomized store/load pairs against a word-array model
    do_reset();
    for (int n = 0; n < 100; n++) begin
      int a, b;
      logic [3:0]  be;
      logic [31:0] wd;
      a  = $urandom_range(0, D7 - 1);
      b  = ($urandom_range(0, 1) == 1) ? a : $urandom_range(0, D7 - 1);
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      do_req($sformatf("rnd%0d_st", n), 1'b1, 32'(a * 4), be, wd, 32'h4000 + 32'(n * 8),
             32'h0, 1'b0, 8);
      for (int k = 0; k < 4; k++)
        if (be[k]) mdl[a][8*k +: 8] = wd[8*k +: 8];
      do_req($sformatf("rnd%0d_ld", n), 1'b0, 32'(b * 4), 4'($urandom_range(0, 15)), 32'h0,
             32'h4004 + 32'(n * 8), mdl[b], 1'b0, 8);
    end

    do_req("l7_oob", 1'b0, 32'(D7 * 4), 4'hF, 32'h0, 32'h5000, 32'h0, 1'b1, 8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mips_dm_responder.md
MIPS_DM_RESPONDER -- requirements
Module: mips_dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning words of storage (power of two).
REQ-002 SHALL have parameter LATENCY, default 1, meaning accept-to-response wait cycles (legal range 1..7).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  meaning the core presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder accepts the request this cycle.
REQ-007 SHALL have port req_we  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  meaning the byte address.
REQ-009 SHALL have port req_be  input  4  meaning byte enables, where bit i selects bits [8i+7:8i].
REQ-010 SHALL have port req_wdata  input  32  meaning the store data.
REQ-011 SHALL have port req_pc  input  32  meaning the PC of the issuing instruction; it is used only for logging.
REQ-012 SHALL have port rsp_valid  output  1  meaning a response is available.
REQ-013 SHALL have port rsp_ready  input  1  meaning the core takes the response.
REQ-014 SHALL have port rsp_rdata  output  32  meaning the load data; it is 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  meaning the access was misaligned or out of range.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
REQ-018 SHALL, on accept, register we/addr/be/wdata/pc, load the wait counter with LATENCY-1, and go to WAIT.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; at 0 it performs the access and goes to RESP, so rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
REQ-020 SHALL, in RESP, hold rsp_valid=1 and keep rsp_rdata and rsp_err stable until rsp_ready=1; on that edge it returns to IDLE.
REQ-021 SHALL NOT accept a new request while in the same cycle as a response handshake (one outstanding request maximum; back-to-back spacing of at least LATENCY+2 cycles).
REQ-022 SHALL form the word index as addr[log2(DEPTH_WORDS)+1:2].
REQ-023 SHALL set rsp_err=1 when addr[1:0]!=0 or addr>=4*DEPTH_WORDS; an error performs no write and returns rdata=0.
REQ-024 SHALL, for a store, update only the enabled bytes; req_be=0 produces a no-op store with err=0.
REQ-025 SHALL, for a load, return the full word regardless of be; byte extraction and extension remain the core's job.
REQ-026 SHALL keep a stalled response (rsp_ready=0) indefinitely, without timeout.
REQ-027 SHALL ignore req_valid in WAIT and RESP, and SHALL NOT register any inputs in those states.

Reset
REQ-028 SHALL, on reset low, asynchronously force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 (combinational from IDLE).
REQ-029 SHALL make storage contents all-zero after reset; a reset asserted during WAIT or RESP discards the pending request, and its store is not performed if still in WAIT.
REQ-030 SHALL leave outputs at reset values until the first rising clk edge after reset deasserts.

Configuration
REQ-031 SHALL provide macro MIPS_DM_WRITE_LOG_EN: when defined, each performed store with non-zero be prints "@<pc>: *<word address> <= <resulting word>" in 8-digit hex.
REQ-032 SHALL make the log format byte-exact to the core's grading format, print only on the access edge, and never print for error or reset-discarded stores.
REQ-033 SHALL, without MIPS_DM_WRITE_LOG_EN, produce no simulation output and leave req_pc unused; cycle behaviour SHALL be identical with and without the macro.

Structure
REQ-034 SHALL place in shared package mips_dm_pkg: the state enum (IDLE/WAIT/RESP), the data/address width constant 32, the byte-enable width constant 4, and the LATENCY bounds.
REQ-035 SHALL use exactly one sub-module, mips_dm_ram: single-port, DEPTH_WORDS x 32, per-byte write enable, synchronous write, combinational read.

Verification
REQ-036 SHALL cover: reset low mid-RESP -> rsp_valid=0 at once, req_ready=1, and a subsequent load of that address returns 0x00000000.
REQ-037 SHALL cover: LATENCY=1, store addr 0x00000010 be=4'b1111 wdata 0xDEADBEEF, then load 0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
REQ-038 SHALL cover: store be=4'b0010 wdata 0x0000AB00 over 0xDEADBEEF -> load returns 0xDEADABEF; with MIPS_DM_WRITE_LOG_EN and pc 0x00003004 the log reads "@00003004: *00000010 <= deadabef".
REQ-039 SHALL cover: load addr 0x00000013 -> err=1, rdata=0; store to 4*DEPTH_WORDS -> err=1, and memory is unchanged.
REQ-040 SHALL cover: hold rsp_ready=0 for 10 cycles -> rsp_valid and data stay stable, req_ready=0 throughout, and a req_valid pulse is ignored.
REQ-041 SHALL cover: LATENCY=7, 100 random aligned load/store pairs checked against a scoreboard -> all data matches, and each response arrives exactly 8 cycles after its accept.
